// File: rtl/wb_gpio_irq.sv
// wb_gpio_irq: Wishbone GPIO slave with synchronized inputs, edge capture and level interrupt
module wb_gpio_irq #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [2:0]       wb_adr_i,
   input  logic [31:0]      wb_dat_i,
   output logic [31:0]      wb_dat_o,
   input  logic [3:0]       wb_sel_i,
   input  logic             wb_we_i,
   input  logic             wb_cyc_i,
   input  logic             wb_stb_i,
   output logic             wb_ack_o,
   input  logic [WIDTH-1:0] gpio_i,
   output logic [WIDTH-1:0] gpio_o,
   output logic [WIDTH-1:0] gpio_dir_o,
   output logic             irq_o
);
   // Registers are held 32 bits wide; bits above WIDTH are forced to 0 and prune away
   localparam logic [31:0] KEEP = (WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'd1 << WIDTH) - 32'd1);
   logic [31:0] s1, s2, prev, out_r, dir_r, rise_en, fall_en, status;
   logic [31:0] wmask, edges, rdata, w1c;
   logic        req, wr;
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [31:0] m);
      return (old & ~m) | (d & m);
   endfunction
   // Request decode, lane mask, edge detection and read mux
   always_comb begin
      req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
      wr = req & wb_we_i;
      wmask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}} & KEEP;
      edges = ((s2 & ~prev & rise_en) | (~s2 & prev & fall_en)) & KEEP;
      w1c = (wr && wb_adr_i == 3'd5) ? (wb_dat_i & wmask) : 32'd0;
      rdata = (wb_adr_i == 3'd0) ? s2 :
              (wb_adr_i == 3'd1) ? out_r :
              (wb_adr_i == 3'd2) ? dir_r :
              (wb_adr_i == 3'd3) ? rise_en :
              (wb_adr_i == 3'd4) ? fall_en :
              (wb_adr_i == 3'd5) ? status : 32'd0;
   end
   // Two-flop synchronizer plus one history stage for edge detection
   always_ff @(posedge clock) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
         prev <= '0;
      end else begin
         s1 <= 32'(gpio_i) & KEEP;
         s2 <= s1;
         prev <= s2;
      end
   end
   // Bus-writable control registers, only enabled byte lanes change
   always_ff @(posedge clock) begin
      if (reset) begin
         out_r <= '0;
         dir_r <= '0;
         rise_en <= '0;
         fall_en <= '0;
      end else begin
         out_r <= (wr && wb_adr_i == 3'd1) ? merge(out_r, wb_dat_i, wmask) : out_r;
         dir_r <= (wr && wb_adr_i == 3'd2) ? merge(dir_r, wb_dat_i, wmask) : dir_r;
         rise_en <= (wr && wb_adr_i == 3'd3) ? merge(rise_en, wb_dat_i, wmask) : rise_en;
         fall_en <= (wr && wb_adr_i == 3'd4) ? merge(fall_en, wb_dat_i, wmask) : fall_en;
      end
   end
   // Edge status: write-1-to-clear, a same-cycle new edge wins over the clear
   always_ff @(posedge clock) begin
      if (reset) status <= '0;
      else status <= (status & ~w1c) | edges;
   end
   // Single-cycle ack, registered read data and level interrupt
   always_ff @(posedge clock) begin
      if (reset) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
         irq_o <= 1'b0;
      end else begin
         wb_ack_o <= req;
         wb_dat_o <= (req & ~wb_we_i) ? rdata : 32'd0;
         irq_o <= |status;
      end
   end
   assign gpio_o = out_r[WIDTH-1:0];
   assign gpio_dir_o = dir_r[WIDTH-1:0];
endmodule

// File: tb/tb_wb_gpio_irq.sv
// tb_wb_gpio_irq: table-driven, directed and randomized checks of wb_gpio_irq
module tb_wb_gpio_irq;
   logic        clock, reset;
   logic [2:0]  wb_adr_i;
   logic [31:0] wb_dat_i, wb_dat_o;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, irq_o;
   logic [7:0]  gpio_i, gpio_o, gpio_dir_o;
   int checks = 0;
   int failures = 0;

   wb_gpio_irq #(.WIDTH(8)) dut (
      .clock(clock), .reset(reset), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
      .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i),
      .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o), .gpio_i(gpio_i), .gpio_o(gpio_o),
      .gpio_dir_o(gpio_dir_o), .irq_o(irq_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   typedef struct {
      logic [2:0]  adr;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic [31:0] exp_rd;
      logic [7:0]  exp_o;
      logic [7:0]  exp_dir;
   } vec_t;
   vec_t vq[$];

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   // Starts and ends on a negedge; ack cycle outputs sampled, then the following cycle's ack
   task automatic xfer(input logic [2:0] a, input logic w, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] rd, output logic [7:0] go, output logic [7:0] gd,
                       output logic irq_a, output logic ak1, output logic ak2);
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_adr_i = a;
      wb_we_i = w;
      wb_sel_i = s;
      wb_dat_i = d;
      tick();
      ak1 = wb_ack_o;
      rd = wb_dat_o;
      go = gpio_o;
      gd = gpio_dir_o;
      irq_a = irq_o;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i = 1'b0;
      tick();
      ak2 = wb_ack_o;
   endtask

   task automatic op(input string nm, input logic [2:0] a, input logic w, input logic [3:0] s,
                     input logic [31:0] d, output logic [31:0] rd, output logic irq_a);
      logic [7:0] go, gd;
      logic ak1, ak2;
      xfer(a, w, s, d, rd, go, gd, irq_a, ak1, ak2);
      check({nm, " ack"}, 32'(ak1), 32'd1);
      check({nm, " ack_one_cycle"}, 32'(ak2), 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic [7:0]  go, gd;
      logic        ia, ak1, ak2;
      logic [7:0]  m_g, m_out, m_dir, m_re, m_fe, m_st, lm, ng;
      logic [31:0] d, exp;
      logic [2:0]  a;
      logic        w;
      logic [3:0]  s;

      reset = 1'b1;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i = 1'b0;
      wb_adr_i = '0;
      wb_sel_i = '0;
      wb_dat_i = '0;
      gpio_i = 8'hA5;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      tick();
      check("reset gpio_o", 32'(gpio_o), 32'h0);
      check("reset gpio_dir_o", 32'(gpio_dir_o), 32'h0);
      check("reset irq_o", 32'(irq_o), 32'h0);
      check("reset ack", 32'(wb_ack_o), 32'h0);
      check("reset dat_o", wb_dat_o, 32'h0);
      repeat (3) tick();

      vq.push_back('{3'd0, 1'b0, 4'hF, 32'h0,        32'h000000A5, 8'h00, 8'h00});
      vq.push_back('{3'd1, 1'b1, 4'h1, 32'h0000003C, 32'h0,        8'h3C, 8'h00});
      vq.push_back('{3'd2, 1'b1, 4'h0, 32'h000000FF, 32'h0,        8'h3C, 8'h00});
      vq.push_back('{3'd2, 1'b0, 4'h0, 32'h0,        32'h0,        8'h3C, 8'h00});
      vq.push_back('{3'd1, 1'b0, 4'h0, 32'h0,        32'h0000003C, 8'h3C, 8'h00});
      vq.push_back('{3'd1, 1'b1, 4'h2, 32'hAB001234, 32'h0,        8'h3C, 8'h00});
      vq.push_back('{3'd1, 1'b1, 4'hF, 32'hFFFFFF5A, 32'h0,        8'h5A, 8'h00});
      vq.push_back('{3'd1, 1'b0, 4'h0, 32'h0,        32'h0000005A, 8'h5A, 8'h00});
      vq.push_back('{3'd2, 1'b1, 4'h1, 32'h0000000F, 32'h0,        8'h5A, 8'h0F});
      vq.push_back('{3'd6, 1'b0, 4'h0, 32'h0,        32'h0,        8'h5A, 8'h0F});
      vq.push_back('{3'd6, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h0,        8'h5A, 8'h0F});
      vq.push_back('{3'd7, 1'b0, 4'h0, 32'h0,        32'h0,        8'h5A, 8'h0F});
      vq.push_back('{3'd0, 1'b1, 4'hF, 32'h000000FF, 32'h0,        8'h5A, 8'h0F});
      vq.push_back('{3'd0, 1'b0, 4'h0, 32'h0,        32'h000000A5, 8'h5A, 8'h0F});
      vq.push_back('{3'd3, 1'b1, 4'h1, 32'h00000001, 32'h0,        8'h5A, 8'h0F});
      vq.push_back('{3'd4, 1'b1, 4'h1, 32'h00000080, 32'h0,        8'h5A, 8'h0F});
      vq.push_back('{3'd3, 1'b0, 4'h0, 32'h0,        32'h00000001, 8'h5A, 8'h0F});
      vq.push_back('{3'd4, 1'b0, 4'h0, 32'h0,        32'h00000080, 8'h5A, 8'h0F});
      vq.push_back('{3'd5, 1'b0, 4'h0, 32'h0,        32'h0,        8'h5A, 8'h0F});
      foreach (vq[i]) begin
         xfer(vq[i].adr, vq[i].we, vq[i].sel, vq[i].dat, rd, go, gd, ia, ak1, ak2);
         check($sformatf("vec%0d ack", i), 32'(ak1), 32'd1);
         check($sformatf("vec%0d ack_one_cycle", i), 32'(ak2), 32'd0);
         check($sformatf("vec%0d gpio_o", i), 32'(go), 32'(vq[i].exp_o));
         check($sformatf("vec%0d gpio_dir_o", i), 32'(gd), 32'(vq[i].exp_dir));
         if (!vq[i].we) check($sformatf("vec%0d rdata", i), rd, vq[i].exp_rd);
      end

      wb_stb_i = 1'b1;
      tick();
      check("stb_without_cyc ack", 32'(wb_ack_o), 32'd0);
      wb_stb_i = 1'b0;

      gpio_i = 8'hA4;
      repeat (4) tick();
      check("ignored fall irq", 32'(irq_o), 32'd0);
      gpio_i = 8'h27;
      tick();
      check("edge E0 irq", 32'(irq_o), 32'd0);
      tick();
      check("edge E1 irq", 32'(irq_o), 32'd0);
      tick();
      check("edge E2 irq", 32'(irq_o), 32'd0);
      tick();
      check("edge E3 irq", 32'(irq_o), 32'd1);
      op("rd status", 3'd5, 1'b0, 4'h0, 32'h0, rd, ia);
      check("status 81", rd, 32'h81);

      op("w1c 01", 3'd5, 1'b1, 4'h1, 32'h01, rd, ia);
      check("w1c 01 irq", 32'(irq_o), 32'd1);
      op("rd status2", 3'd5, 1'b0, 4'h0, 32'h0, rd, ia);
      check("status 80", rd, 32'h80);
      op("w1c 80", 3'd5, 1'b1, 4'h1, 32'h80, rd, ia);
      check("w1c 80 irq in ack cycle", 32'(ia), 32'd1);
      check("w1c 80 irq after", 32'(irq_o), 32'd0);
      op("rd status3", 3'd5, 1'b0, 4'h0, 32'h0, rd, ia);
      check("status 00", rd, 32'h0);

      gpio_i = 8'h26;
      repeat (4) tick();
      gpio_i = 8'h27;
      tick();
      tick();
      op("w1c at E2", 3'd5, 1'b1, 4'h1, 32'h01, rd, ia);
      op("rd status4", 3'd5, 1'b0, 4'h0, 32'h0, rd, ia);
      check("set wins over w1c", rd, 32'h01);
      check("set wins irq", 32'(irq_o), 32'd1);

      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_adr_i = 3'd1;
      wb_we_i = 1'b0;
      reset = 1'b1;
      tick();
      check("reset mid ack", 32'(wb_ack_o), 32'd0);
      check("reset mid gpio_o", 32'(gpio_o), 32'd0);
      check("reset mid dir", 32'(gpio_dir_o), 32'd0);
      check("reset mid irq", 32'(irq_o), 32'd0);
      check("reset mid dat_o", wb_dat_o, 32'd0);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      tick();
      check("reset mid ack2", 32'(wb_ack_o), 32'd0);
      reset = 1'b0;
      repeat (5) tick();
      op("post reset rise_en", 3'd3, 1'b0, 4'h0, 32'h0, rd, ia);
      check("post reset rise_en", rd, 32'h0);
      op("post reset status", 3'd5, 1'b0, 4'h0, 32'h0, rd, ia);
      check("post reset status", rd, 32'h0);

      m_g = gpio_i;
      m_out = '0;
      m_dir = '0;
      m_re = '0;
      m_fe = '0;
      m_st = '0;
      for (int it = 0; it < 250; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            ng = 8'($urandom);
            gpio_i = ng;
            repeat (4) tick();
            m_st = m_st | (ng & ~m_g & m_re) | (~ng & m_g & m_fe);
            m_g = ng;
            check($sformatf("rnd%0d irq after pins", it), 32'(irq_o), 32'(m_st != 0));
         end else begin
            a = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            s = 4'($urandom);
            d = $urandom;
            lm = {8{s[0]}};
            exp = (a == 3'd0) ? 32'(m_g) : (a == 3'd1) ? 32'(m_out) : (a == 3'd2) ? 32'(m_dir) :
                  (a == 3'd3) ? 32'(m_re) : (a == 3'd4) ? 32'(m_fe) : (a == 3'd5) ? 32'(m_st) : 32'd0;
            if (w) begin
               if (a == 3'd1) m_out = (m_out & ~lm) | (d[7:0] & lm);
               if (a == 3'd2) m_dir = (m_dir & ~lm) | (d[7:0] & lm);
               if (a == 3'd3) m_re = (m_re & ~lm) | (d[7:0] & lm);
               if (a == 3'd4) m_fe = (m_fe & ~lm) | (d[7:0] & lm);
               if (a == 3'd5) m_st = m_st & ~(d[7:0] & lm);
            end
            xfer(a, w, s, d, rd, go, gd, ia, ak1, ak2);
            check($sformatf("rnd%0d ack", it), 32'(ak1), 32'd1);
            check($sformatf("rnd%0d ack_one_cycle", it), 32'(ak2), 32'd0);
            if (!w) check($sformatf("rnd%0d read adr%0d", it, a), rd, exp);
            check($sformatf("rnd%0d gpio_o", it), 32'(go), 32'(m_out));
            check($sformatf("rnd%0d gpio_dir_o", it), 32'(gd), 32'(m_dir));
            check($sformatf("rnd%0d irq", it), 32'(irq_o), 32'(m_st != 0));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
